// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises an async active-low reset, stretches it, then
// releases NUM_OUT active-high reset outputs in order with GAP-cycle spacing.
module rst_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRETCH     = 16,
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned GAP         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               rst_done
);

  localparam int unsigned CNT_W = $clog2(STRETCH + 1);
  localparam int unsigned GAP_W = $clog2(GAP + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("rst_sequencer: SYNC_STAGES must be in 2..4");
  end
  if (STRETCH < 1 || STRETCH > 65535) begin : g_bad_stretch
    $error("rst_sequencer: STRETCH must be in 1..65535");
  end
  if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
    $error("rst_sequencer: NUM_OUT must be in 1..8");
  end
  if (GAP < 1 || GAP > 255) begin : g_bad_gap
    $error("rst_sequencer: GAP must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_STRETCH = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [GAP_W-1:0]     r_gap;
  logic [GAP_W-1:0]     w_gap_nxt;
  logic [NUM_OUT-1:0]   r_rst_out;
  logic [NUM_OUT-1:0]   w_rst_out_nxt;
  logic                 r_done;
  logic                 w_done_nxt;

  logic                 w_sync_q;
  logic                 w_stretch_end;
  logic                 w_gap_end;
  logic [NUM_OUT-1:0]   w_shift;

  assign w_sync_q      = r_sync[SYNC_STAGES-1];
  assign w_stretch_end = (r_cnt == CNT_W'(STRETCH - 1));
  assign w_gap_end     = (r_gap == GAP_W'(GAP - 1));
  // Next release pattern: one more low bit, filling from bit 0 upward.
  assign w_shift       = r_rst_out << 1;

  // Reset synchroniser: release only propagates through the flop chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // State, counters and output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_SYNC;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_rst_out <= '1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gap     <= w_gap_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_gap_nxt     = r_gap;
    w_rst_out_nxt = r_rst_out;
    w_done_nxt    = r_done;

    case (r_state)
      // Counter is still zero here, so the first synchronised cycle counts as stretch cycle 1.
      S_SYNC: begin
        if (w_sync_q) begin
          if (w_stretch_end) begin
            w_rst_out_nxt = w_shift;
            w_gap_nxt     = '0;
            if (w_shift == '0) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_RELEASE;
            end
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = S_STRETCH;
          end
        end
      end

      S_STRETCH: begin
        if (sw_rst_req) begin
          w_cnt_nxt = '0;
        end else if (w_stretch_end) begin
          w_rst_out_nxt = w_shift;
          w_gap_nxt     = '0;
          if (w_shift == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (sw_rst_req) begin
          w_state_nxt   = S_STRETCH;
          w_cnt_nxt     = '0;
          w_gap_nxt     = '0;
          w_rst_out_nxt = '1;
          w_done_nxt    = 1'b0;
        end else if (w_gap_end) begin
          w_rst_out_nxt = w_shift;
          w_gap_nxt     = '0;
          if (w_shift == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end

      S_DONE: begin
        if (sw_rst_req) begin
          w_state_nxt   = S_STRETCH;
          w_cnt_nxt     = '0;
          w_gap_nxt     = '0;
          w_rst_out_nxt = '1;
          w_done_nxt    = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_SYNC;
      end
    endcase
  end

  assign rst_out  = r_rst_out;
  assign rst_done = r_done;

endmodule
